// File: rtl/counters_pkg.sv
// rtl/counters_pkg.sv - shared counter mode encodings
package counters_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } count_mode_e;

endpackage

// File: rtl/mod_counter_if.sv
// rtl/mod_counter_if.sv - control/status bundle of the modulo counter
interface mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, up, load, d,
        input  q, tc, wrap, ovf
    );

    modport slave (
        input  en, up, load, d,
        output q, tc, wrap, ovf
    );
endinterface

// File: rtl/mod_counter_dff_n.sv
// rtl/mod_counter_dff_n.sv - WIDTH-bit D register, sync active-high reset, load enable
module dff_n #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;
endmodule

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - up/down modulo counter with load, wrap pulse and sticky overflow
module mod_counter
    import counters_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int SATURATE = 0
) (
    input  logic          clk,
    input  logic          reset,
    mod_counter_if.slave  bus
);
    localparam bit               SAT_EN  = (SATURATE == int'(MODE_SAT));
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH still compares correctly against d.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             count_en, ovf_en;
    logic             at_max, at_min;

    assign at_max = (count_q == MAX_VAL);
    assign at_min = (count_q == '0);

    always_comb begin
        count_d  = count_q;
        wrap_d   = 1'b0;
        ovf_d    = ovf_q;
        count_en = 1'b0;
        ovf_en   = 1'b0;
        if (bus.load) begin
            count_en = 1'b1;
            ovf_en   = 1'b1;
            ovf_d    = 1'b0;
            count_d  = ({1'b0, bus.d} >= MOD_EXT) ? MAX_VAL : bus.d;
        end else if (bus.en) begin
            count_en = 1'b1;
            if (bus.up) begin
                if (!at_max) begin
                    count_d = count_q + WIDTH'(1);
                end else if (!SAT_EN) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!at_min) begin
                    count_d = count_q - WIDTH'(1);
                end else if (!SAT_EN) begin
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
                end
            end
            // A wrap is the only event that sets the sticky flag.
            if (wrap_d) begin
                ovf_en = 1'b1;
                ovf_d  = 1'b1;
            end
        end
    end

    dff_n #(.WIDTH(WIDTH)) u_count (
        .clk   (clk),
        .reset (reset),
        .en_i  (count_en),
        .d_i   (count_d),
        .q_o   (count_q)
    );

    dff_n #(.WIDTH(1)) u_wrap (
        .clk   (clk),
        .reset (reset),
        .en_i  (1'b1),
        .d_i   (wrap_d),
        .q_o   (wrap_q)
    );

    dff_n #(.WIDTH(1)) u_ovf (
        .clk   (clk),
        .reset (reset),
        .en_i  (ovf_en),
        .d_i   (ovf_d),
        .q_o   (ovf_q)
    );

    assign bus.q    = count_q;
    assign bus.wrap = wrap_q;
    assign bus.ovf  = ovf_q;
    assign bus.tc   = bus.up ? at_max : at_min;
endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - scoreboard bench for three mod_counter configurations
module tb_mod_counter;

    typedef struct {
        int q;
        bit wrap;
        bit ovf;
        bit tc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mod_counter_if #(.WIDTH(4)) if0 ();
    mod_counter_if #(.WIDTH(4)) if1 ();
    mod_counter_if #(.WIDTH(3)) if2 ();

    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    mod_counter #(.WIDTH(3), .MODULUS(5),  .SATURATE(0)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];

    int m_q[3];
    bit m_ovf[3];
    int mod_n[3] = '{10, 10, 5};
    bit sat_m[3] = '{1'b0, 1'b1, 1'b0};
    int dmask[3] = '{15, 15, 7};

    // Reference: count as a plain integer and decide wrap/saturate by range test.
    function automatic exp_t model_step(int i, bit r, bit ld, int dv, bit e, bit u);
        exp_t x;
        bit   w  = 1'b0;
        int   dd = dv & dmask[i];
        int   t;
        if (r) begin
            m_q[i]   = 0;
            m_ovf[i] = 1'b0;
        end else if (ld) begin
            m_q[i]   = (dd < mod_n[i]) ? dd : mod_n[i] - 1;
            m_ovf[i] = 1'b0;
        end else if (e) begin
            t = m_q[i] + (u ? 1 : -1);
            if (t < 0 || t >= mod_n[i]) begin
                if (!sat_m[i]) begin
                    m_q[i]   = (t + mod_n[i]) % mod_n[i];
                    w        = 1'b1;
                    m_ovf[i] = 1'b1;
                end
            end else begin
                m_q[i] = t;
            end
        end
        x.q    = m_q[i];
        x.wrap = w;
        x.ovf  = m_ovf[i];
        x.tc   = u ? (m_q[i] == mod_n[i] - 1) : (m_q[i] == 0);
        return x;
    endfunction

    task automatic step(bit r, bit ld, int dv, bit e, bit u);
        @(negedge clk);
        reset    = r;
        if0.load = ld; if1.load = ld; if2.load = ld;
        if0.en   = e;  if1.en   = e;  if2.en   = e;
        if0.up   = u;  if1.up   = u;  if2.up   = u;
        if0.d    = 4'(dv);
        if1.d    = 4'(dv);
        if2.d    = 3'(dv);
        sb0.push_back(model_step(0, r, ld, dv, e, u));
        sb1.push_back(model_step(1, r, ld, dv, e, u));
        sb2.push_back(model_step(2, r, ld, dv, e, u));
    endtask

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb0.size() > 0) begin
                x = sb0.pop_front();
                check("c0.q", int'(if0.q), x.q);
                check("c0.wrap", int'(if0.wrap), int'(x.wrap));
                check("c0.ovf", int'(if0.ovf), int'(x.ovf));
                check("c0.tc", int'(if0.tc), int'(x.tc));
            end
            if (sb1.size() > 0) begin
                x = sb1.pop_front();
                check("c1.q", int'(if1.q), x.q);
                check("c1.wrap", int'(if1.wrap), int'(x.wrap));
                check("c1.ovf", int'(if1.ovf), int'(x.ovf));
                check("c1.tc", int'(if1.tc), int'(x.tc));
            end
            if (sb2.size() > 0) begin
                x = sb2.pop_front();
                check("c2.q", int'(if2.q), x.q);
                check("c2.wrap", int'(if2.wrap), int'(x.wrap));
                check("c2.ovf", int'(if2.ovf), int'(x.ovf));
                check("c2.tc", int'(if2.tc), int'(x.tc));
            end
        end
    end

    initial begin
        if0.en = 1'b0; if0.up = 1'b1; if0.load = 1'b0; if0.d = '0;
        if1.en = 1'b0; if1.up = 1'b1; if1.load = 1'b0; if1.d = '0;
        if2.en = 1'b0; if2.up = 1'b1; if2.load = 1'b0; if2.d = '0;

        // basic up-count wrap
        repeat (2) step(1, 0, 0, 0, 1);
        repeat (10) step(0, 0, 0, 1, 1);
        // down-count wrap
        step(1, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 1, 0);
        // load priority and clamping, then hold
        step(0, 1, 12, 1, 1);
        step(0, 1, 3, 0, 1);
        repeat (3) step(0, 0, 0, 0, 1);
        // saturate at both ends
        step(0, 1, 9, 0, 1);
        repeat (3) step(0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        // non-power-of-two up-count
        step(1, 0, 0, 0, 1);
        repeat (6) step(0, 0, 0, 1, 1);
        // reset mid-operation overriding load
        step(1, 0, 0, 0, 1);
        repeat (16) step(0, 0, 0, 1, 1);
        step(1, 1, 2, 1, 1);
        step(0, 0, 0, 1, 1);

        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom));
        end

        @(posedge clk);
        #2;
        check("sb0.drained", sb0.size(), 0);
        check("sb1.drained", sb1.size(), 0);
        check("sb2.drained", sb2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter and load-data width in bits.
REQ-002 SHALL have parameter MODULUS, default 10: count range is 0..MODULUS-1, with 2 <= MODULUS <= 2**WIDTH.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at the range ends, 1 = hold at the range ends.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have port en, input, 1 bit: count enable.
REQ-007 SHALL have port up, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-008 SHALL have port load, input, 1 bit: synchronous parallel load.
REQ-009 SHALL have port d, input, WIDTH bits: load value.
REQ-010 SHALL have port q, output, WIDTH bits: registered count.
REQ-011 SHALL have port tc, output, 1 bit: combinational terminal count.
REQ-012 SHALL have port wrap, output, 1 bit: registered single-cycle wrap pulse.
REQ-013 SHALL have port ovf, output, 1 bit: registered sticky wrap flag.

Function
REQ-014 SHALL apply per-edge priority: reset, then load, then en, then hold.
REQ-015 SHALL, on load, set q to d, or to MODULUS-1 when d >= MODULUS.
REQ-016 SHALL, on load, clear ovf and drive wrap to 0 in the following cycle.
REQ-017 SHALL, with en=1 and up=1, increment q by 1.
REQ-018 SHALL, with en=1 and up=0, decrement q by 1.
REQ-019 SHALL, when SATURATE=0 and q=MODULUS-1, en=1, up=1: set q=0, wrap=1, ovf=1.
REQ-020 SHALL, when SATURATE=0 and q=0, en=1, up=0: set q=MODULUS-1, wrap=1, ovf=1.
REQ-021 SHALL, when SATURATE=1 at either range end counting outward: hold q, keep wrap=0, leave ovf unchanged.
REQ-022 SHALL register wrap, asserting it in exactly the cycle q shows the wrapped value; wrap SHALL be 0 in every other cycle.
REQ-023 SHALL hold q, hold ovf and drive wrap=0 when en=0 and load=0.
REQ-024 SHALL drive tc combinationally as (up AND q==MODULUS-1) OR (NOT up AND q==0), independent of en.
REQ-025 SHALL never present q >= MODULUS.
REQ-026 SHALL compute all arithmetic at WIDTH bits, with no dependence on natural 2**WIDTH overflow.

Reset
REQ-027 SHALL, on reset=1 at a rising edge, set q=0, wrap=0, ovf=0, overriding load and en.
REQ-028 SHALL honour a reset asserted mid-count on the next edge, and resume counting from 0 on the first edge after reset deasserts.
REQ-029 SHALL have no asynchronous reset path.

Structure
REQ-030 SHALL take the SATURATE mode encodings (MODE_WRAP=0, MODE_SAT=1) from the shared package counters_pkg.
REQ-031 SHALL hold q, wrap and ovf in instances of sub-module dff_n: a WIDTH-parametrised D register with synchronous active-high reset and load enable.
REQ-032 SHALL place next-state and clamp logic in mod_counter, outside dff_n.

Verification
REQ-033 SHALL cover basic up-count wrap: WIDTH=4, MODULUS=10; reset 2 cycles, then en=1, up=1 for 10 edges -> q steps 1..9 then 0; wrap=1 only on the q=0 cycle; ovf=1 thereafter; tc=1 while q=9.
REQ-034 SHALL cover down-count wrap: reset, then en=1, up=0, 1 edge -> q=9, wrap=1, ovf=1; next edge -> q=8, wrap=0.
REQ-035 SHALL cover load priority and clamping: load=1, d=12, en=1 -> q=9, ovf=0; then load=1, d=3 -> q=3; then load=0, en=0 for 3 edges -> q=3 held.
REQ-036 SHALL cover saturate mode: SATURATE=1, load d=9, then en=1, up=1 for 3 edges -> q=9, wrap=0, ovf=0; then up=0 from a load of 0 -> q=0 held.
REQ-037 SHALL cover reset mid-operation: count to q=6 with ovf=1, then assert reset together with load=1, d=2 -> q=0, ovf=0, wrap=0; then deassert reset with en=1, up=1 -> q=1.
REQ-038 SHALL cover a non-power-of-two edge case: WIDTH=3, MODULUS=5, up-count 6 edges -> q sequence 1,2,3,4,0,1.
